// File: rtl/syn_md_if.sv
// Sync-marker receive bundle: the line and enable going into the detector,
// the strobes and measurements coming back out of it.
interface syn_md_if #(
    parameter int PER_W = 24
);
    logic             syn_md_in;
    logic             rx_en;
    logic             syn_det;
    logic             width_err;
    logic [7:0]       syn_width;
    logic [PER_W-1:0] syn_period;
    logic             period_valid;
    logic [7:0]       det_cnt;

    // Upstream side: drives the sync line and enable, observes results.
    modport master (
        output syn_md_in, rx_en,
        input  syn_det, width_err, syn_width, syn_period, period_valid, det_cnt
    );

    // Detector side.
    modport slave (
        input  syn_md_in, rx_en,
        output syn_det, width_err, syn_width, syn_period, period_valid, det_cnt
    );
endinterface

// File: rtl/syn_md_rx.sv
// Sync-marker receiver: synchronizes the async sync line, measures each high
// pulse, accepts pulses inside [MIN_W, MAX_W], and reports the rise-to-rise
// period between consecutive accepted markers.
module syn_md_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_W       = 14,
    parameter int MAX_W       = 20,
    parameter int PER_W       = 24
) (
    input  logic     clkin,
    input  logic     rst,
    syn_md_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HIGH  = 2'd2,
        STUCK = 2'd3
    } state_t;

    localparam logic [7:0] MIN_W8 = 8'(MIN_W);
    localparam logic [7:0] MAX_W8 = 8'(MAX_W);

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s, s_d, rise, fall;
    logic [7:0]             w;
    logic [PER_W-1:0]       p, p_inc, cand;
    logic                   accept, reject;

    logic                   det_q, err_q, pvalid_q, seen_q;
    logic [7:0]             width_q, cnt_q;
    logic [PER_W-1:0]       period_q;

    assign s     = sync_q[SYNC_STAGES-1];
    assign rise  = s & ~s_d;
    assign fall  = ~s & s_d;
    assign p_inc = (&p) ? p : p + PER_W'(1);

    // Synchronizer chain and edge-detect delay. Deliberately not reset: a
    // reset mid-pulse must keep seeing the line high so the FSM waits in IDLE
    // for the line to drop instead of treating the tail as a fresh rise.
    always_ff @(posedge clkin) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.syn_md_in};
        s_d    <= s;
    end

    // FSM state register.
    always_ff @(posedge clkin) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and accept/reject decisions; a disabled detector sits in IDLE.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        if (!bus.rx_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    // Only arm on a low line so a pulse already in flight is skipped.
                    if (!s) state_nxt = ARMED;
                end
                ARMED: begin
                    if (rise) state_nxt = HIGH;
                end
                HIGH: begin
                    if (fall) begin
                        if (w >= MIN_W8 && w <= MAX_W8) accept = 1'b1;
                        else                            reject = 1'b1;
                        state_nxt = ARMED;
                    end else if (s && w == MAX_W8) begin
                        // Pulse is about to exceed MAX_W: flag it once, then wait it out.
                        reject    = 1'b1;
                        state_nxt = STUCK;
                    end
                end
                STUCK: begin
                    if (!s) state_nxt = ARMED;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // High-width counter: starts at 1 on the rise cycle, saturates at 255.
    always_ff @(posedge clkin) begin
        if (rst)                                   w <= 8'd0;
        else if (rise)                             w <= 8'd1;
        else if (state == HIGH && s && w != 8'hFF) w <= w + 8'd1;
    end

    // Period counter and rise candidate. On acceptance the counter is
    // re-based to the accepted pulse's width, which is exactly the number of
    // cycles since its rise; rejected pulses only overwrite the candidate.
    always_ff @(posedge clkin) begin
        if (rst) begin
            p    <= '0;
            cand <= '0;
        end else begin
            if (!bus.rx_en)  p <= '0;
            else if (accept) p <= PER_W'(w);
            else             p <= p_inc;
            if (rise) cand <= p_inc;
        end
    end

    // Strobes and the measurements reported for each accepted pulse.
    always_ff @(posedge clkin) begin
        if (rst) begin
            det_q    <= 1'b0;
            err_q    <= 1'b0;
            width_q  <= 8'd0;
            period_q <= '0;
            pvalid_q <= 1'b0;
            seen_q   <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            det_q <= accept;
            err_q <= reject;
            if (!bus.rx_en) begin
                pvalid_q <= 1'b0;
                seen_q   <= 1'b0;
            end else if (accept) begin
                width_q  <= w;
                period_q <= cand;
                cnt_q    <= cnt_q + 8'd1;
                seen_q   <= 1'b1;
                if (seen_q) pvalid_q <= 1'b1;
            end
        end
    end

    assign bus.syn_det      = det_q;
    assign bus.width_err    = err_q;
    assign bus.syn_width    = width_q;
    assign bus.syn_period   = period_q;
    assign bus.period_valid = pvalid_q;
    assign bus.det_cnt      = cnt_q;

endmodule

// File: tb/tb_syn_md_rx.sv
// Directed bench for syn_md_rx with default parameters (MIN_W 14, MAX_W 20).
module tb_syn_md_rx;

    logic clkin = 1'b0;
    logic rst   = 1'b1;

    syn_md_if #(.PER_W(24)) bus ();

    syn_md_rx #(
        .SYNC_STAGES(2), .MIN_W(14), .MAX_W(20), .PER_W(24)
    ) dut (
        .clkin(clkin),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clkin = ~clkin;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int det_seen = 0;
    int err_seen = 0;
    int last_err_cyc = 0;

    always @(posedge clkin) cyc <= cyc + 1;

    // Strobe event log sampled away from the active edge.
    always @(negedge clkin) begin
        if (bus.syn_det)   det_seen <= det_seen + 1;
        if (bus.width_err) begin
            err_seen     <= err_seen + 1;
            last_err_cyc <= cyc;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clkin);
    endtask

    // Line high for wd cycles starting at the current negedge; returns at the fall.
    task automatic drive_pulse(input int wd);
        bus.syn_md_in = 1'b1;
        repeat (wd) @(negedge clkin);
        bus.syn_md_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(4);
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_reset();
        bus.syn_md_in = 1'b0;
        bus.rx_en     = 1'b0;
        rst           = 1'b1;
        idle(5);
        tests++;
        if ({bus.syn_det, bus.width_err, bus.period_valid} !== 3'b000 ||
            bus.syn_width !== 8'd0 || bus.det_cnt !== 8'd0 || bus.syn_period !== 24'd0) begin
            fails++;
            $display("FAIL reset_outputs det=%b err=%b pv=%b w=%0d cnt=%0d per=%0d expected all 0",
                     bus.syn_det, bus.width_err, bus.period_valid, bus.syn_width,
                     bus.det_cnt, bus.syn_period);
        end
        rst       = 1'b0;
        bus.rx_en = 1'b1;
        idle(4);
    endtask

    task automatic test_single();
        drive_pulse(16);
        idle(2);
        tests++;
        if (bus.syn_det !== 1'b0) begin
            fails++;
            $display("FAIL single_early det=%b expected 0", bus.syn_det);
        end
        idle(1);
        tests++;
        if (bus.syn_det !== 1'b1 || bus.syn_width !== 8'd16 || bus.det_cnt !== 8'd1 ||
            bus.period_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_accept det=%b w=%0d cnt=%0d pv=%b expected 1/16/1/0",
                     bus.syn_det, bus.syn_width, bus.det_cnt, bus.period_valid);
        end
        idle(1);
        tests++;
        if (bus.syn_det !== 1'b0) begin
            fails++;
            $display("FAIL single_one_cycle det=%b expected 0", bus.syn_det);
        end
        idle(20);
    endtask

    task automatic test_period();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_pulse(16);
            idle(3);
            tests++;
            if (bus.syn_det !== 1'b1 || bus.det_cnt !== 8'(i + 1)) begin
                fails++;
                $display("FAIL period_det_%0d det=%b cnt=%0d expected 1/%0d",
                         i, bus.syn_det, bus.det_cnt, i + 1);
            end
            tests++;
            if (i == 0 && bus.period_valid !== 1'b0) begin
                fails++;
                $display("FAIL period_first_valid pv=%b expected 0", bus.period_valid);
            end else if (i > 0 && (bus.period_valid !== 1'b1 || bus.syn_period !== 24'd1000)) begin
                fails++;
                $display("FAIL period_%0d pv=%b per=%0d expected 1/1000",
                         i, bus.period_valid, bus.syn_period);
            end
            idle(981);
        end
    endtask

    task automatic test_width_sweep();
        int widths[4]  = '{13, 14, 20, 21};
        bit accepts[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            int d0 = det_seen;
            int e0 = err_seen;
            drive_pulse(widths[i]);
            idle(10);
            tests++;
            if ((det_seen - d0) !== (accepts[i] ? 1 : 0) ||
                (err_seen - e0) !== (accepts[i] ? 0 : 1)) begin
                fails++;
                $display("FAIL sweep_w%0d dets=%0d errs=%0d expected %0d/%0d", widths[i],
                         det_seen - d0, err_seen - e0, accepts[i] ? 1 : 0, accepts[i] ? 0 : 1);
            end
            if (accepts[i]) begin
                tests++;
                if (bus.syn_width !== 8'(widths[i])) begin
                    fails++;
                    $display("FAIL sweep_width_w%0d got=%0d expected %0d",
                             widths[i], bus.syn_width, widths[i]);
                end
            end
            idle(20);
        end
    endtask

    task automatic test_stuck();
        int d0 = det_seen;
        int e0 = err_seen;
        int rise_cyc = cyc;
        bus.syn_md_in = 1'b1;
        idle(100);
        bus.syn_md_in = 1'b0;
        idle(10);
        tests++;
        if ((err_seen - e0) !== 1 || (det_seen - d0) !== 0) begin
            fails++;
            $display("FAIL stuck_strobes errs=%0d dets=%0d expected 1/0",
                     err_seen - e0, det_seen - d0);
        end
        tests++;
        if ((last_err_cyc - rise_cyc) !== 23) begin
            fails++;
            $display("FAIL stuck_latency got=%0d expected 23", last_err_cyc - rise_cyc);
        end
        d0 = det_seen;
        drive_pulse(16);
        idle(10);
        tests++;
        if ((det_seen - d0) !== 1 || bus.det_cnt !== 8'd6) begin
            fails++;
            $display("FAIL stuck_recover dets=%0d cnt=%0d expected 1/6",
                     det_seen - d0, bus.det_cnt);
        end
        idle(20);
    endtask

    task automatic test_enable();
        int d0;
        int e0;
        bus.rx_en = 1'b0;
        idle(3);
        tests++;
        if (bus.period_valid !== 1'b0 || bus.det_cnt !== 8'd6 || bus.syn_width !== 8'd16) begin
            fails++;
            $display("FAIL enable_hold pv=%b cnt=%0d w=%0d expected 0/6/16",
                     bus.period_valid, bus.det_cnt, bus.syn_width);
        end
        d0 = det_seen;
        e0 = err_seen;
        bus.syn_md_in = 1'b1;
        idle(5);
        bus.rx_en = 1'b1;
        idle(5);
        bus.syn_md_in = 1'b0;
        idle(10);
        tests++;
        if ((det_seen - d0) !== 0 || (err_seen - e0) !== 0) begin
            fails++;
            $display("FAIL enable_inflight dets=%0d errs=%0d expected 0/0",
                     det_seen - d0, err_seen - e0);
        end
        drive_pulse(16);
        idle(3);
        tests++;
        if (bus.syn_det !== 1'b1 || bus.period_valid !== 1'b0 || bus.det_cnt !== 8'd7) begin
            fails++;
            $display("FAIL enable_next det=%b pv=%b cnt=%0d expected 1/0/7",
                     bus.syn_det, bus.period_valid, bus.det_cnt);
        end
        idle(30);
    endtask

    task automatic test_rst_mid();
        int d0;
        int e0 = err_seen;
        drive_pulse(16);
        idle(484);
        drive_pulse(10);
        idle(490);
        drive_pulse(16);
        idle(3);
        tests++;
        if (bus.syn_det !== 1'b1 || bus.syn_period !== 24'd1000 || bus.period_valid !== 1'b1 ||
            bus.det_cnt !== 8'd9 || (err_seen - e0) !== 1) begin
            fails++;
            $display("FAIL reject_keeps_period det=%b per=%0d pv=%b cnt=%0d errs=%0d expected 1/1000/1/9/1",
                     bus.syn_det, bus.syn_period, bus.period_valid, bus.det_cnt, err_seen - e0);
        end
        idle(20);
        bus.syn_md_in = 1'b1;
        idle(8);
        rst = 1'b1;
        idle(2);
        tests++;
        if ({bus.syn_det, bus.width_err, bus.period_valid} !== 3'b000 ||
            bus.syn_width !== 8'd0 || bus.det_cnt !== 8'd0 || bus.syn_period !== 24'd0) begin
            fails++;
            $display("FAIL rst_mid_outputs det=%b err=%b pv=%b w=%0d cnt=%0d per=%0d expected all 0",
                     bus.syn_det, bus.width_err, bus.period_valid, bus.syn_width,
                     bus.det_cnt, bus.syn_period);
        end
        rst = 1'b0;
        d0 = det_seen;
        e0 = err_seen;
        idle(5);
        bus.syn_md_in = 1'b0;
        idle(10);
        tests++;
        if ((det_seen - d0) !== 0 || (err_seen - e0) !== 0 || bus.det_cnt !== 8'd0) begin
            fails++;
            $display("FAIL rst_mid_abandon dets=%0d errs=%0d cnt=%0d expected 0/0/0",
                     det_seen - d0, err_seen - e0, bus.det_cnt);
        end
        drive_pulse(16);
        idle(10);
        tests++;
        if (bus.det_cnt !== 8'd1 || bus.syn_width !== 8'd16) begin
            fails++;
            $display("FAIL rst_mid_next cnt=%0d w=%0d expected 1/16", bus.det_cnt, bus.syn_width);
        end
        idle(20);
    endtask

    task automatic test_back_to_back();
        int d0 = det_seen;
        drive_pulse(16);
        idle(1);
        drive_pulse(18);
        idle(10);
        tests++;
        if ((det_seen - d0) !== 2 || bus.det_cnt !== 8'd3 || bus.syn_width !== 8'd18) begin
            fails++;
            $display("FAIL back_to_back dets=%0d cnt=%0d w=%0d expected 2/3/18",
                     det_seen - d0, bus.det_cnt, bus.syn_width);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_period();
        test_width_sweep();
        test_stuck();
        test_enable();
        test_rst_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
